inv_round_col_feeder: RTL and testbench

- Column-serial front end of the iterative AES decryption round.
- Accepts one 128-bit state (already through InvShiftRows/InvSubBytes) plus a 128-bit round key, and applies AddRoundKey.
- Streams the result as four 32-bit columns, one per accepted beat, to the column-wide inverse-MixColumns unit.
- Flags the final round so the downstream stage bypasses InvMixColumns.

---
 rtl/aes_pkg.sv | 32 +++
 rtl/add_round_key.sv | 17 +
 rtl/inv_round_col_feeder.sv | 99 +++++++++
 tb/tb_inv_round_col_feeder.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | aes_pkg : shared AES widths, feeder FSM states, column slice helper |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package aes_pkg;

   localparam int AES_STATE_W  = 128;
   localparam int AES_COL_W    = 32;
   localparam int AES_NUM_COLS = 4;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SEND = 1'b1
   } feeder_state_e;

   // Column 0 sits in the most significant word of the state.
   function automatic logic [AES_COL_W-1:0] col_sel(input logic [AES_STATE_W-1:0] state,
                                                    input logic [1:0]             idx);
      logic [AES_COL_W-1:0] col;
      col = '0;
      case (idx)
         2'd0:    col = state[127:96];
         2'd1:    col = state[95:64];
         2'd2:    col = state[63:32];
         default: col = state[31:0];
      endcase
      return col;
   endfunction

endpackage
`default_nettype wire

// File: rtl/add_round_key.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | add_round_key : combinational AddRoundKey (state XOR round key)     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module add_round_key
   import aes_pkg::*;
(
   input  logic [AES_STATE_W-1:0] state_in,
   input  logic [AES_STATE_W-1:0] round_key,
   output logic [AES_STATE_W-1:0] state_out
);

   assign state_out = state_in ^ round_key;

endmodule
`default_nettype wire

// File: rtl/inv_round_col_feeder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | inv_round_col_feeder : AddRoundKey then column-serial streaming     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module inv_round_col_feeder
   import aes_pkg::*;
#(
   parameter int NUM_COLS = 4,
   parameter int COL_W    = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [AES_STATE_W-1:0] state_in,
   input  logic [AES_STATE_W-1:0] round_key,
   input  logic                   last_round,
   input  logic                   abort,
   output logic [COL_W-1:0]       col_out,
   output logic [1:0]             col_idx,
   output logic                   col_valid,
   input  logic                   col_ready,
   output logic                   col_last,
   output logic                   col_bypass,
   output logic                   blk_done
);

   localparam logic [1:0] LAST_IDX = 2'(NUM_COLS - 1);

   feeder_state_e          state_q, state_d;
   logic [AES_STATE_W-1:0] state_reg_q, state_reg_d;
   logic [AES_STATE_W-1:0] keyed_state;
   logic [1:0]             col_idx_q, col_idx_d;
   logic                   bypass_q, bypass_d;
   logic                   blk_done_q, blk_done_d;

   add_round_key u_add_round_key (
      .state_in  (state_in),
      .round_key (round_key),
      .state_out (keyed_state)
   );

   always_comb begin
      state_d     = state_q;
      state_reg_d = state_reg_q;
      col_idx_d   = col_idx_q;
      bypass_d    = bypass_q;
      blk_done_d  = 1'b0;
      if (state_q == IDLE) begin
         // abort outranks a new block arriving in the same cycle
         if (in_valid && !abort) begin
            state_reg_d = keyed_state;
            bypass_d    = last_round;
            col_idx_d   = 2'd0;
            state_d     = SEND;
         end
      end else begin
         if (abort) begin
            state_d   = IDLE;
            col_idx_d = 2'd0;
         end else if (col_ready) begin
            if (col_idx_q == LAST_IDX) begin
               state_d    = IDLE;
               col_idx_d  = 2'd0;
               blk_done_d = 1'b1;
            end else begin
               col_idx_d = col_idx_q + 2'd1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         state_reg_q <= '0;
         col_idx_q   <= 2'd0;
         bypass_q    <= 1'b0;
         blk_done_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         state_reg_q <= state_reg_d;
         col_idx_q   <= col_idx_d;
         bypass_q    <= bypass_d;
         blk_done_q  <= blk_done_d;
      end
   end

   assign in_ready   = (state_q == IDLE);
   assign col_valid  = (state_q == SEND);
   assign col_out    = col_sel(state_reg_q, col_idx_q);
   assign col_idx    = col_idx_q;
   assign col_last   = col_valid && (col_idx_q == LAST_IDX);
   assign col_bypass = bypass_q;
   assign blk_done   = blk_done_q;

endmodule
`default_nettype wire

// File: tb/tb_inv_round_col_feeder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_inv_round_col_feeder : randomized self-checking bench           |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_inv_round_col_feeder;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] state_in;
   logic [127:0] round_key;
   logic         last_round;
   logic         abort;
   logic [31:0]  col_out;
   logic [1:0]   col_idx;
   logic         col_valid;
   logic         col_ready;
   logic         col_last;
   logic         col_bypass;
   logic         blk_done;

   int total = 0;
   int bad   = 0;

   localparam logic [127:0] BASIC_S = 128'h00112233_44556677_8899aabb_ccddeeff;
   localparam logic [127:0] ONES    = {128{1'b1}};

   logic [31:0] obs_col [4];
   logic [1:0]  obs_idx [4];
   logic        obs_last[4];
   logic        obs_byp [4];
   int          obs_n;
   int          obs_viol;
   logic        obs_done;

   inv_round_col_feeder #(.NUM_COLS(4), .COL_W(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .state_in   (state_in),
      .round_key  (round_key),
      .last_round (last_round),
      .abort      (abort),
      .col_out    (col_out),
      .col_idx    (col_idx),
      .col_valid  (col_valid),
      .col_ready  (col_ready),
      .col_last   (col_last),
      .col_bypass (col_bypass),
      .blk_done   (blk_done)
   );

   always #5 clk = ~clk;

   // Reference: column i of (state ^ key), column 0 in the top word.
   function automatic logic [31:0] ref_col(input logic [127:0] s, input logic [127:0] k, input int i);
      logic [127:0] x;
      x = (s ^ k) >> (32 * (3 - i));
      return x[31:0];
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_accept(input logic [127:0] s, input logic [127:0] k, input logic last);
      int guard = 0;
      while (!in_ready && guard < 50) begin
         tick();
         guard++;
      end
      if (!in_ready) begin
         total++;
         bad++;
         $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready);
      end
      state_in   = s;
      round_key  = k;
      last_round = last;
      in_valid   = 1'b1;
      tick();
      in_valid   = 1'b0;
      state_in   = rand128();
      round_key  = rand128();
      last_round = $urandom_range(1);
   endtask

   // Records accepted beats from index 'first' on, plus any change seen while stalled.
   task automatic collect(input int first, input int stall_pct);
      int          cyc = 0;
      bit          stalled = 0;
      logic [31:0] hc = '0;
      logic [1:0]  hi = '0;
      logic        hl = 1'b0;
      logic        hb = 1'b0;
      obs_n    = first;
      obs_viol = 0;
      while (obs_n < 4 && cyc < 300) begin
         col_ready = ($urandom_range(99) >= stall_pct);
         if (stalled && (col_valid !== 1'b1 || col_out !== hc || col_idx !== hi ||
                         col_last !== hl || col_bypass !== hb))
            obs_viol++;
         if (col_valid && col_ready) begin
            obs_col[obs_n]  = col_out;
            obs_idx[obs_n]  = col_idx;
            obs_last[obs_n] = col_last;
            obs_byp[obs_n]  = col_bypass;
            obs_n++;
         end
         stalled = col_valid && !col_ready;
         hc = col_out; hi = col_idx; hl = col_last; hb = col_bypass;
         tick();
         cyc++;
      end
      col_ready = 1'b0;
      obs_done  = blk_done;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; abort = 1'b0; col_ready = 1'b0;
      state_in = '0; round_key = '0; last_round = 1'b0;
      tick(); tick();
      rst = 1'b0;
      total++;
      if ({in_ready, col_valid, col_idx, col_bypass, blk_done, col_last, col_out} !==
          {1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 32'h0}) begin
         bad++;
         $display("FAIL reset_state: got rdy=%0b vld=%0b idx=%0d byp=%0b done=%0b last=%0b col=%h",
                  in_ready, col_valid, col_idx, col_bypass, blk_done, col_last, col_out);
      end
   endtask

   task automatic test_basic();
      logic [31:0] ec[4];
      ec[0] = 32'hffeeddcc; ec[1] = 32'hbbaa9988; ec[2] = 32'h77665544; ec[3] = 32'h33221100;
      do_accept(BASIC_S, ONES, 1'b0);
      total++;
      if (col_valid !== 1'b1 || col_idx !== 2'd0) begin
         bad++;
         $display("FAIL basic_latency: vld=%0b idx=%0d required vld=1 idx=0", col_valid, col_idx);
      end
      collect(0, 0);
      total++;
      if (obs_n != 4) begin
         bad++;
         $display("FAIL basic_beats: got %0d beats required 4", obs_n);
      end
      for (int i = 0; i < 4; i++) begin
         total++;
         if ({obs_col[i], obs_idx[i], obs_last[i], obs_byp[i]} !== {ec[i], 2'(i), (i == 3), 1'b0}) begin
            bad++;
            $display("FAIL basic_beat%0d: col=%h idx=%0d last=%0b byp=%0b required col=%h idx=%0d last=%0b byp=0",
                     i, obs_col[i], obs_idx[i], obs_last[i], obs_byp[i], ec[i], i, (i == 3));
         end
      end
      total++;
      if ({obs_done, in_ready, col_valid} !== 3'b110) begin
         bad++;
         $display("FAIL basic_done: done=%0b rdy=%0b vld=%0b required 1 1 0", obs_done, in_ready, col_valid);
      end
      tick();
      total++;
      if (blk_done !== 1'b0) begin
         bad++;
         $display("FAIL basic_done_pulse: blk_done=%0b required 0", blk_done);
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] ec[4];
      ec[0] = 32'hffeeddcc; ec[1] = 32'hbbaa9988; ec[2] = 32'h77665544; ec[3] = 32'h33221100;
      do_accept(BASIC_S, ONES, 1'b0);
      col_ready = 1'b1;
      tick();
      col_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         total++;
         if ({col_valid, col_out, col_idx, col_last} !== {1'b1, ec[1], 2'd1, 1'b0}) begin
            bad++;
            $display("FAIL bp_hold%0d: vld=%0b col=%h idx=%0d required vld=1 col=%h idx=1",
                     i, col_valid, col_out, col_idx, ec[1]);
         end
         tick();
      end
      collect(1, 0);
      total++;
      if (obs_n != 4 || obs_done !== 1'b1) begin
         bad++;
         $display("FAIL bp_finish: beats=%0d done=%0b required 4 1", obs_n, obs_done);
      end
      for (int i = 1; i < 4; i++) begin
         total++;
         if ({obs_col[i], obs_idx[i]} !== {ec[i], 2'(i)}) begin
            bad++;
            $display("FAIL bp_beat%0d: col=%h idx=%0d required col=%h idx=%0d", i, obs_col[i], obs_idx[i], ec[i], i);
         end
      end
   endtask

   task automatic test_last_round();
      logic [127:0] s, k;
      s = rand128();
      do_accept(s, '0, 1'b1);
      collect(0, 30);
      for (int i = 0; i < 4; i++) begin
         total++;
         if ({obs_col[i], obs_byp[i]} !== {ref_col(s, '0, i), 1'b1}) begin
            bad++;
            $display("FAIL last_beat%0d: col=%h byp=%0b required col=%h byp=1", i, obs_col[i], obs_byp[i], ref_col(s, '0, i));
         end
      end
      s = rand128(); k = rand128();
      do_accept(s, k, 1'b0);
      collect(0, 0);
      for (int i = 0; i < 4; i++) begin
         total++;
         if ({obs_col[i], obs_byp[i]} !== {ref_col(s, k, i), 1'b0}) begin
            bad++;
            $display("FAIL nolast_beat%0d: col=%h byp=%0b required col=%h byp=0", i, obs_col[i], obs_byp[i], ref_col(s, k, i));
         end
      end
   endtask

   task automatic test_abort();
      logic [127:0] s, k;
      // abort on beat 2
      do_accept(BASIC_S, ONES, 1'b0);
      col_ready = 1'b1;
      tick(); tick();
      total++;
      if (col_idx !== 2'd2) begin
         bad++;
         $display("FAIL abort_pre_idx: idx=%0d required 2", col_idx);
      end
      abort = 1'b1;
      tick();
      abort = 1'b0; col_ready = 1'b0;
      total++;
      if ({col_valid, in_ready, blk_done} !== 3'b010) begin
         bad++;
         $display("FAIL abort_b2: vld=%0b rdy=%0b done=%0b required 0 1 0", col_valid, in_ready, blk_done);
      end
      s = rand128(); k = rand128();
      do_accept(s, k, 1'b0);
      total++;
      if ({col_valid, col_idx, col_out} !== {1'b1, 2'd0, ref_col(s, k, 0)}) begin
         bad++;
         $display("FAIL abort_restart: vld=%0b idx=%0d col=%h required 1 0 %h", col_valid, col_idx, col_out, ref_col(s, k, 0));
      end
      collect(0, 0);
      total++;
      if (obs_n != 4 || obs_col[3] !== ref_col(s, k, 3) || obs_done !== 1'b1) begin
         bad++;
         $display("FAIL abort_restart_end: beats=%0d col3=%h done=%0b required 4 %h 1", obs_n, obs_col[3], obs_done, ref_col(s, k, 3));
      end
      // abort together with the column-3 handshake
      tick();
      do_accept(s, k, 1'b1);
      col_ready = 1'b1;
      tick(); tick(); tick();
      abort = 1'b1;
      tick();
      abort = 1'b0; col_ready = 1'b0;
      total++;
      if ({col_valid, in_ready, blk_done} !== 3'b010) begin
         bad++;
         $display("FAIL abort_b3: vld=%0b rdy=%0b done=%0b required 0 1 0", col_valid, in_ready, blk_done);
      end
      tick();
      total++;
      if (blk_done !== 1'b0) begin
         bad++;
         $display("FAIL abort_b3_late: blk_done=%0b required 0", blk_done);
      end
      // abort in IDLE blocks acceptance
      in_valid = 1'b1; abort = 1'b1; state_in = s; round_key = k;
      tick();
      in_valid = 1'b0; abort = 1'b0;
      total++;
      if ({col_valid, in_ready} !== 2'b01) begin
         bad++;
         $display("FAIL abort_idle: vld=%0b rdy=%0b required 0 1", col_valid, in_ready);
      end
   endtask

   task automatic test_reset_mid();
      do_accept(rand128(), rand128(), 1'b1);
      col_ready = 1'b1;
      tick(); tick();
      rst = 1'b1; in_valid = 1'b1; state_in = rand128(); last_round = 1'b1;
      tick();
      total++;
      if ({in_ready, col_valid, col_idx, col_bypass, blk_done, col_last, col_out} !==
          {1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 32'h0}) begin
         bad++;
         $display("FAIL rst_mid: rdy=%0b vld=%0b idx=%0d byp=%0b done=%0b last=%0b col=%h required 1 0 0 0 0 0 0",
                  in_ready, col_valid, col_idx, col_bypass, blk_done, col_last, col_out);
      end
      tick();
      rst = 1'b0; in_valid = 1'b0; col_ready = 1'b0;
      tick();
      total++;
      if ({col_valid, blk_done, col_bypass} !== 3'b000) begin
         bad++;
         $display("FAIL rst_no_accept: vld=%0b done=%0b byp=%0b required 0 0 0", col_valid, blk_done, col_bypass);
      end
   endtask

   task automatic test_back_to_back();
      logic [127:0] sa, ka, sb, kb;
      logic [31:0]  b_col[8];
      logic [1:0]   b_idx[8];
      int           b_cyc[8];
      int           n = 0;
      int           done_cyc = -1;
      sa = rand128(); ka = rand128(); sb = rand128(); kb = rand128();
      col_ready = 1'b1; last_round = 1'b0;
      state_in = sa; round_key = ka; in_valid = 1'b1;
      tick();
      state_in = sb; round_key = kb;
      for (int c = 0; c < 20 && n < 8; c++) begin
         if (blk_done && done_cyc < 0) done_cyc = c;
         if (col_valid) begin
            b_col[n] = col_out; b_idx[n] = col_idx; b_cyc[n] = c;
            n++;
            if (n == 5) in_valid = 1'b0;
         end
         tick();
      end
      in_valid = 1'b0; col_ready = 1'b0;
      total++;
      if (n != 8) begin
         bad++;
         $display("FAIL b2b_count: beats=%0d required 8", n);
      end else begin
         for (int i = 0; i < 8; i++) begin
            logic [31:0] e;
            e = (i < 4) ? ref_col(sa, ka, i) : ref_col(sb, kb, i - 4);
            total++;
            if ({b_col[i], b_idx[i]} !== {e, 2'(i % 4)}) begin
               bad++;
               $display("FAIL b2b_beat%0d: col=%h idx=%0d required col=%h idx=%0d", i, b_col[i], b_idx[i], e, i % 4);
            end
         end
         total++;
         if (done_cyc != 4 || b_cyc[4] - b_cyc[0] != 5 || b_cyc[7] != 8) begin
            bad++;
            $display("FAIL b2b_timing: done_cyc=%0d period=%0d last_beat_cyc=%0d required 4 5 8",
                     done_cyc, b_cyc[4] - b_cyc[0], b_cyc[7]);
         end
      end
      tick();
   endtask

   task automatic test_random();
      logic [127:0] s, k;
      logic         lr;
      for (int b = 0; b < 8; b++) begin
         s = rand128(); k = rand128(); lr = $urandom_range(1);
         do_accept(s, k, lr);
         collect(0, $urandom_range(0, 60));
         total++;
         if (obs_n != 4 || obs_viol != 0 || obs_done !== 1'b1) begin
            bad++;
            $display("FAIL rand%0d_flow: beats=%0d holdviol=%0d done=%0b required 4 0 1", b, obs_n, obs_viol, obs_done);
         end
         for (int i = 0; i < 4; i++) begin
            total++;
            if ({obs_col[i], obs_idx[i], obs_last[i], obs_byp[i]} !== {ref_col(s, k, i), 2'(i), (i == 3), lr}) begin
               bad++;
               $display("FAIL rand%0d_beat%0d: col=%h idx=%0d last=%0b byp=%0b required col=%h idx=%0d last=%0b byp=%0b",
                        b, i, obs_col[i], obs_idx[i], obs_last[i], obs_byp[i], ref_col(s, k, i), i, (i == 3), lr);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_last_round();
      test_abort();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
